core_sequencer: RTL

Multi-cycle control FSM for the core. Drives the 3-bit `state` bus consumed by the decode stage and all other stages. It stretches each stage to cover instruction-memory, data-memory, FPU and UART I/O handshakes. It also gates register-file and PC write enables, and provides a debug halt/resume path.

---
 rtl/core_sequencer_if.sv | 65 ++++++
 rtl/core_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
//
// Purpose: bundles the stage code, the handshake pairs and the decode flags
// that run between core_sequencer and the rest of the core.
//
// Modports:
//   master - the sequencer: drives state, request/enable pulses and halted,
//            samples ready/done/valid, decode flags and debug controls
//   slave  - the surrounding core (or a testbench): the reverse directions
//
// Signals:
//   state[2:0]            stage code (0 FETCH .. 5 HALT)
//   imem_req/imem_ready   instruction fetch handshake, instr_we load pulse
//   use_fpu .. writef     registered decode flags
//   fpu_start/fpu_done    FPU launch / result valid
//   dmem_req/dmem_ready   data memory handshake
//   io_rx_valid/io_rx_pop UART RX byte consume
//   io_tx_ready/io_tx_push UART TX byte push
//   rf_we/frf_we/pc_we    writeback enables
//   halt_req/resume/halted debug halt path
// -----------------------------------------------------------------------------
interface core_sequencer_if;
  logic [2:0] state;
  logic       imem_req;
  logic       imem_ready;
  logic       instr_we;
  logic       use_fpu;
  logic       mem_read;
  logic       mem_write;
  logic       data_in;
  logic       data_out;
  logic       reg_write;
  logic       writef;
  logic       fpu_start;
  logic       fpu_done;
  logic       dmem_req;
  logic       dmem_ready;
  logic       io_rx_valid;
  logic       io_rx_pop;
  logic       io_tx_ready;
  logic       io_tx_push;
  logic       rf_we;
  logic       frf_we;
  logic       pc_we;
  logic       halt_req;
  logic       resume;
  logic       halted;

  modport master (
    output state, imem_req, instr_we, fpu_start, dmem_req, io_rx_pop,
           io_tx_push, rf_we, frf_we, pc_we, halted,
    input  imem_ready, use_fpu, mem_read, mem_write, data_in, data_out,
           reg_write, writef, fpu_done, dmem_ready, io_rx_valid,
           io_tx_ready, halt_req, resume
  );

  modport slave (
    input  state, imem_req, instr_we, fpu_start, dmem_req, io_rx_pop,
           io_tx_push, rf_we, frf_we, pc_we, halted,
    output imem_ready, use_fpu, mem_read, mem_write, data_in, data_out,
           reg_write, writef, fpu_done, dmem_ready, io_rx_valid,
           io_tx_ready, halt_req, resume
  );
endinterface

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//
// Purpose: multi-cycle control FSM of the core. Walks FETCH -> DECODE ->
// EXEC -> [MEM] -> WRITE, stretching stages over the instruction-memory,
// FPU, UART and data-memory handshakes, gates the register-file / PC write
// enables and offers a debug HALT / resume path.
//
// Ports:
//   clk          core clock
//   rst          asynchronous, active-high reset; forces every output low
//   bus          core_sequencer_if.master (stage code, handshakes, flags)
//   cycle_cnt    32-bit count of non-HALT cycles     (SEQ_PERF_CNT_EN only)
//   instret_cnt  32-bit count of WRITE cycles        (SEQ_PERF_CNT_EN only)
//
// Optional feature: define SEQ_PERF_CNT_EN to add the two performance
// counters and their ports. Without it the ports and counters are absent.
// -----------------------------------------------------------------------------
module core_sequencer (
  input  logic                    clk,
  input  logic                    rst,
  core_sequencer_if.master        bus
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             instret_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WRITE  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t state_reg, state_next;

  // High during the first EXEC cycle only; DECODE always leads into EXEC.
  logic exec_first_reg;

  // Decode flags captured on the first EXEC cycle.
  logic lat_use_fpu_reg, lat_mem_read_reg, lat_mem_write_reg;
  logic lat_data_in_reg, lat_data_out_reg, lat_reg_write_reg, lat_writef_reg;

  // On the first EXEC cycle the latches are not loaded yet, so decisions
  // look at the live decode flags; afterwards they use the latched copies
  // (data_in/data_out are cleared by decode after that cycle).
  logic eff_use_fpu, eff_mem_read, eff_mem_write, eff_data_in, eff_data_out;
  logic cls_fpu, cls_in, cls_out;
  logic exec_done;

  assign eff_use_fpu   = exec_first_reg ? bus.use_fpu   : lat_use_fpu_reg;
  assign eff_mem_read  = exec_first_reg ? bus.mem_read  : lat_mem_read_reg;
  assign eff_mem_write = exec_first_reg ? bus.mem_write : lat_mem_write_reg;
  assign eff_data_in   = exec_first_reg ? bus.data_in   : lat_data_in_reg;
  assign eff_data_out  = exec_first_reg ? bus.data_out  : lat_data_out_reg;

  // Class priority FPU > IN > OUT > plain.
  assign cls_fpu = eff_use_fpu;
  assign cls_in  = ~eff_use_fpu & eff_data_in;
  assign cls_out = ~eff_use_fpu & ~eff_data_in & eff_data_out;

  // fpu_done in the launch cycle belongs to an older operation, so it is
  // ignored there; plain instructions finish in their first EXEC cycle.
  always_comb begin
    if (cls_fpu)      exec_done = bus.fpu_done & ~exec_first_reg;
    else if (cls_in)  exec_done = bus.io_rx_valid;
    else if (cls_out) exec_done = bus.io_tx_ready;
    else              exec_done = 1'b1;
  end

  // State register and flag latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_FETCH;
      exec_first_reg    <= 1'b0;
      lat_use_fpu_reg   <= 1'b0;
      lat_mem_read_reg  <= 1'b0;
      lat_mem_write_reg <= 1'b0;
      lat_data_in_reg   <= 1'b0;
      lat_data_out_reg  <= 1'b0;
      lat_reg_write_reg <= 1'b0;
      lat_writef_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      exec_first_reg <= (state_reg == ST_DECODE);
      if (state_reg == ST_EXEC && exec_first_reg) begin
        lat_use_fpu_reg   <= bus.use_fpu;
        lat_mem_read_reg  <= bus.mem_read;
        lat_mem_write_reg <= bus.mem_write;
        lat_data_in_reg   <= bus.data_in;
        lat_data_out_reg  <= bus.data_out;
        lat_reg_write_reg <= bus.reg_write;
        lat_writef_reg    <= bus.writef;
      end
    end
  end

  // Next state and outputs. rst holds every output low, even though the
  // registered state already reads FETCH while reset is asserted.
  always_comb begin
    state_next     = state_reg;
    bus.state      = 3'd0;
    bus.imem_req   = 1'b0;
    bus.instr_we   = 1'b0;
    bus.fpu_start  = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.io_rx_pop  = 1'b0;
    bus.io_tx_push = 1'b0;
    bus.rf_we      = 1'b0;
    bus.frf_we     = 1'b0;
    bus.pc_we      = 1'b0;
    bus.halted     = 1'b0;
    if (!rst) begin
      bus.state = state_reg;
      case (state_reg)
        ST_FETCH: begin
          bus.imem_req = 1'b1;
          if (bus.imem_ready) begin
            bus.instr_we = 1'b1;
            state_next   = ST_DECODE;
          end
        end
        ST_DECODE: state_next = ST_EXEC;
        ST_EXEC: begin
          bus.fpu_start = exec_first_reg & cls_fpu;
          if (exec_done) begin
            bus.io_rx_pop  = cls_in;
            bus.io_tx_push = cls_out;
            state_next = (eff_mem_read | eff_mem_write) ? ST_MEM : ST_WRITE;
          end
        end
        ST_MEM: begin
          bus.dmem_req = 1'b1;
          if (bus.dmem_ready) state_next = ST_WRITE;
        end
        ST_WRITE: begin
          bus.pc_we  = 1'b1;
          bus.rf_we  = lat_reg_write_reg & ~lat_writef_reg;
          bus.frf_we = lat_writef_reg;
          // The only point where a debug halt request is honoured.
          state_next = bus.halt_req ? ST_HALT : ST_FETCH;
        end
        ST_HALT: begin
          bus.halted = 1'b1;
          if (bus.resume) state_next = ST_FETCH;
        end
        default: state_next = ST_FETCH;  // codes 6-7 recover to FETCH
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] instret_cnt_reg;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_reg   <= 32'd0;
      instret_cnt_reg <= 32'd0;
    end else begin
      if (state_reg != ST_HALT) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (state_reg == ST_WRITE) instret_cnt_reg <= instret_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt   = rst ? 32'd0 : cycle_cnt_reg;
  assign instret_cnt = rst ? 32'd0 : instret_cnt_reg;
`endif

endmodule
